mul_add_seq: RTL and testbench

Sequential shift-add multiply-accumulate unit: computes p = a × b + c on 32-bit unsigned operands, producing an exact 64-bit result. It is the inverse companion of the combinational divider in the multiply/divide lab. Feeding it the divider's quotient (a), divisor (b) and remainder (c) reconstructs the dividend, so the bench can run round-trip checks. It runs one partial product per clock under a start/done handshake.

---
 rtl/mul_add_seq.sv | 105 ++++++++++
 tb/tb_mul_add_seq.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/mul_add_seq.sv
// Sequential shift-add multiply-accumulate: p = a * b + c, 32-bit unsigned operands, exact 64-bit result.
// Latency: 32 clocks from the accepting edge to the done pulse; one partial product per clock.
// Backpressure: start is only sampled while busy=0; operands and start are ignored during a run.
module mul_add_seq (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [31:0] c,
    output logic        busy,
    output logic        done,
    output logic [63:0] p
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [31:0] mreg;
    logic [63:0] mcand;
    logic [63:0] acc;
    logic [63:0] acc_nxt;
    logic [4:0]  cnt;

    // busy and done decode straight from the state register, so they are
    // registered and can never be high together.
    assign busy = (state == RUN);
    assign done = (state == DONE);

    // Conditional add of the current partial product; the 64-bit sum cannot
    // overflow because the largest result is 2^64 - 2^32.
    assign acc_nxt = mreg[0] ? (acc + mcand) : acc;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: a start in DONE is accepted back-to-back.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (cnt == 5'd31) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = start ? RUN : IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Datapath: latch operands on accept, iterate one bit per clock, and
    // publish the result only on the final iteration so p holds otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mreg  <= '0;
            mcand <= '0;
            acc   <= '0;
            cnt   <= '0;
            p     <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        mreg  <= a;
                        mcand <= {32'b0, b};
                        acc   <= {32'b0, c};
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    acc   <= acc_nxt;
                    mcand <= mcand << 1;
                    mreg  <= mreg >> 1;
                    cnt   <= cnt + 5'd1;
                    if (cnt == 5'd31) begin
                        p <= acc_nxt;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul_add_seq.sv
module tb_mul_add_seq;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c;
    logic        busy;
    logic        done;
    logic [63:0] p;

    int vectors;
    int miscompares;

    mul_add_seq dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .c     (c),
        .busy  (busy),
        .done  (done),
        .p     (p)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Waits for done after an accept edge, sampling #1 after each rising edge.
    // Returns the number of edges taken and whether busy ever dropped early.
    task automatic wait_done(output int n, output int busy_bad);
        n = 0;
        busy_bad = 0;
        while (done !== 1'b1 && n < 40) begin
            @(posedge clk);
            #1;
            n++;
            if (done !== 1'b1 && busy !== 1'b1) busy_bad++;
        end
    endtask

    task automatic run_op(input logic [31:0] ia, input logic [31:0] ib, input logic [31:0] ic,
                          input logic [63:0] exp, input string tag);
        int n;
        int bb;
        @(negedge clk);
        a = ia;
        b = ib;
        c = ic;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk({tag, " busy@accept"}, {63'b0, busy}, 64'd1);
        wait_done(n, bb);
        chk({tag, " latency"}, n, 64'd32);
        chk({tag, " busy gaps"}, bb, 64'd0);
        chk({tag, " busy@done"}, {63'b0, busy}, 64'd0);
        chk({tag, " p"}, p, exp);
    endtask

    initial begin
        int n;
        int bb;
        int dones;
        logic [31:0] x;
        logic [31:0] y;

        vectors = 0;
        miscompares = 0;
        rst_n = 1'b0;
        start = 1'b0;
        a = '0;
        b = '0;
        c = '0;

        // Reset state
        #12;
        chk("reset busy", {63'b0, busy}, 64'd0);
        chk("reset done", {63'b0, done}, 64'd0);
        chk("reset p", p, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic and boundary operands
        run_op(32'd7, 32'd3, 32'd1, 64'd22, "basic");
        @(posedge clk);
        #1;
        chk("done one cycle", {63'b0, done}, 64'd0);
        chk("p held after done", p, 64'd22);
        run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFF00000000, "max");
        run_op(32'h80000000, 32'd2, 32'd0, 64'h100000000, "msb");
        run_op(32'd0, 32'd123, 32'd5, 64'd5, "a zero");
        run_op(32'd9, 32'd0, 32'd0, 64'd0, "b zero");

        // Input isolation and back-to-back accept
        @(negedge clk);
        a = 32'd10;
        b = 32'd10;
        c = 32'd0;
        start = 1'b1;
        @(posedge clk);
        #1;
        dones = 0;
        for (int i = 1; i <= 32; i++) begin
            @(negedge clk);
            a = $urandom;
            b = $urandom;
            c = $urandom;
            @(posedge clk);
            #1;
            if (done === 1'b1) dones++;
        end
        chk("iso single done", dones, 64'd1);
        chk("iso done at E32", {63'b0, done}, 64'd1);
        chk("iso p", p, 64'd100);
        @(negedge clk);
        a = 32'd6;
        b = 32'd7;
        c = 32'd8;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("b2b busy", {63'b0, busy}, 64'd1);
        chk("b2b done drop", {63'b0, done}, 64'd0);
        chk("b2b p held", p, 64'd100);
        wait_done(n, bb);
        chk("b2b latency", n, 64'd32);
        chk("b2b p", p, 64'd50);

        // Reset mid-run
        @(negedge clk);
        a = 32'd5;
        b = 32'd5;
        c = 32'd0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst busy", {63'b0, busy}, 64'd0);
        chk("midrst done", {63'b0, done}, 64'd0);
        chk("midrst p", p, 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        dones = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1 || busy === 1'b1) dones++;
        end
        chk("midrst no done", dones, 64'd0);
        run_op(32'd2, 32'd3, 32'd4, 64'd10, "post reset");

        // Round trip through divider reference
        for (int i = 0; i < 1000; i++) begin
            x = $urandom;
            y = (i % 3 == 0) ? $urandom_range(1, 1000) : $urandom;
            if (i == 0) y = 32'd1;
            if (i == 1) begin x = 32'd5; y = 32'd100; end
            if (i == 2) x = 32'hFFFFFFFF;
            if (i == 3) begin x = 32'hFFFFFFFF; y = 32'd1; end
            if (y == 32'd0) y = 32'd7;
            run_op(x / y, y, x % y, {32'b0, x}, "roundtrip");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
